// File: rtl/pwm_capture_if.sv
`default_nettype none
// =====================================================================
// pwm_capture_if : byte-wide register bus between a host and pwm_capture
// Revision: 1.0
// =====================================================================
interface pwm_capture_if;
    logic [7:0] b_addr_i;
    logic [7:0] b_data_i;
    logic [7:0] b_data_o;
    logic       b_write_i;

    modport master (output b_addr_i, output b_data_i, output b_write_i, input b_data_o);
    modport slave  (input b_addr_i, input b_data_i, input b_write_i, output b_data_o);
endinterface
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// =====================================================================
// pwm_capture : measures period and high time of an asynchronous PWM input.
// Optional glitch filter after the synchronizer: PWM_CAPTURE_FILTER_EN.
// Revision: 1.0
// =====================================================================
module pwm_capture #(
    parameter int CNT_BITS = 16
) (
    input  logic         clk_i,
    input  logic         nrst_i,
    pwm_capture_if.slave bus,
    input  logic         pwm_i,
    output logic         irq_o
);
    localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_t;

    state_t              state;
    logic                sync_1, sync_2, level, level_d, rise, fall;
    logic                en, hold, ie, oneshot, valid, ovf;
    logic [CNT_BITS-1:0] period_cnt, high_cnt;
    logic [15:0]         period_res, high_res;
    logic                wr_ctl, wr_sts;
    logic                unused_wdata;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= pwm_i;
            sync_2 <= sync_1;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    // Output follows the synchronizer only after three identical samples in a row.
    logic [1:0] hist;
    logic       held;
    logic       agree;

    assign agree = (sync_2 == hist[0]) && (sync_2 == hist[1]);
    assign level = agree ? sync_2 : held;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            hist <= 2'b00;
            held <= 1'b0;
        end else begin
            hist <= {hist[0], sync_2};
            held <= level;
        end
    end
`else
    assign level = sync_2;
`endif

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            level_d <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            level_d <= level;
            rise    <= level & ~level_d;
            fall    <= ~level & level_d;
        end
    end

    assign wr_ctl       = bus.b_write_i && (bus.b_addr_i == 8'h00);
    assign wr_sts       = bus.b_write_i && (bus.b_addr_i == 8'h01);
    assign unused_wdata = &{1'b0, bus.b_data_i[4:1]};

    // Hardware updates come after bus writes so a same-cycle set or EN clear wins.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state      <= ST_IDLE;
            en         <= 1'b0;
            hold       <= 1'b0;
            ie         <= 1'b0;
            oneshot    <= 1'b0;
            valid      <= 1'b0;
            ovf        <= 1'b0;
            period_cnt <= '0;
            high_cnt   <= '0;
            period_res <= 16'h0000;
            high_res   <= 16'h0000;
        end else begin
            if (wr_ctl) begin
                en      <= bus.b_data_i[7];
                hold    <= bus.b_data_i[6];
                ie      <= bus.b_data_i[5];
                oneshot <= bus.b_data_i[0];
            end
            if (wr_sts && bus.b_data_i[0]) valid <= 1'b0;
            if (wr_sts && bus.b_data_i[1]) ovf   <= 1'b0;

            if (!en) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_ARM;
                    ST_ARM: begin
                        if (rise) begin
                            state      <= ST_HIGH;
                            period_cnt <= CNT_ONE;
                            high_cnt   <= CNT_ONE;
                        end
                    end
                    ST_HIGH, ST_LOW: begin
                        if (period_cnt == CNT_MAX) begin
                            ovf <= 1'b1;
                            if (!hold) begin
                                period_res <= 16'(CNT_MAX);
                                high_res   <= (state == ST_HIGH) ? 16'(CNT_MAX) : 16'(high_cnt);
                            end
                            state <= ST_ARM;
                        end else if (state == ST_LOW && rise) begin
                            if (!hold) begin
                                period_res <= 16'(period_cnt);
                                high_res   <= 16'(high_cnt);
                            end
                            valid      <= 1'b1;
                            period_cnt <= CNT_ONE;
                            high_cnt   <= CNT_ONE;
                            if (oneshot) begin
                                state <= ST_IDLE;
                                en    <= 1'b0;
                            end else begin
                                state <= ST_HIGH;
                            end
                        end else begin
                            period_cnt <= period_cnt + CNT_ONE;
                            if (state == ST_HIGH) begin
                                if (fall) state    <= ST_LOW;
                                else      high_cnt <= high_cnt + CNT_ONE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        bus.b_data_o = 8'h00;
        case (bus.b_addr_i)
            8'h00:   bus.b_data_o = {en, hold, ie, 4'b0000, oneshot};
            8'h01:   bus.b_data_o = {5'b00000, level, ovf, valid};
            8'h02:   bus.b_data_o = period_res[15:8];
            8'h03:   bus.b_data_o = period_res[7:0];
            8'h04:   bus.b_data_o = high_res[15:8];
            8'h05:   bus.b_data_o = high_res[7:0];
            default: bus.b_data_o = 8'h00;
        endcase
    end

    assign irq_o = valid & ie;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// tb_pwm_capture : directed stimulus, timestamp-based reference model compared
// every cycle, plus hand-computed register expectations.
module tb_pwm_capture;
    localparam int MAXC   = 65535;
    localparam int P_IDLE = 0, P_ARM = 1, P_HIGH = 2, P_LOW = 3;

    logic clk = 1'b0, nrst = 1'b0, pwm = 1'b0, irq;
    pwm_capture_if bus();
    pwm_capture #(.CNT_BITS(16)) dut (
        .clk_i (clk), .nrst_i(nrst), .bus(bus), .pwm_i(pwm), .irq_o(irq)
    );
    always #5 clk = ~clk;

    int checks = 0, errors = 0, nprint = 0;
    logic       chk_on = 1'b0, busy = 1'b0, wr = 1'b0;
    logic [7:0] req_addr = 8'h00, wdata = 8'h00, sweep = 8'h00;
    assign bus.b_addr_i  = busy ? req_addr : sweep;
    assign bus.b_data_i  = wdata;
    assign bus.b_write_i = wr;

    // background address sweep so every register is compared each few cycles
    always @(posedge clk) begin
        #1;
        sweep = (sweep == 8'h06) ? 8'h00 : sweep + 8'h01;
    end

    // PWM generator
    int   pw_per = 100, pw_high = 30, pw_seq = 0, gen_seq = 0, pw_ph = 0;
    logic pw_mode = 1'b0, pw_lvl = 1'b0;
    always @(posedge clk) begin
        #1;
        if (pw_seq != gen_seq) begin
            gen_seq = pw_seq;
            pw_ph   = 0;
        end
        if (pw_mode) begin
            pwm   = (pw_ph < pw_high);
            pw_ph = (pw_ph + 1 >= pw_per) ? 0 : pw_ph + 1;
        end else begin
            pwm = pw_lvl;
        end
    end

    // Reference model: pin samples are delayed by the input pipeline, then
    // period/high are differences of accepted-edge timestamps.
    int         cyc = 0, t_rise = 0, t_fall = 0, phase = P_IDLE;
    logic [7:0] ph = 8'h00, gh = 8'h00, vh;
    logic       gnew, acc_rise, acc_fall, en_q, hold_q, os_q;
    logic       m_en = 0, m_hold = 0, m_ie = 0, m_os = 0, m_valid = 0, m_ovf = 0, m_lvl = 0;
    logic [15:0] m_per = 16'h0, m_high = 16'h0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            {m_en, m_hold, m_ie, m_os, m_valid, m_ovf, m_lvl} = 7'b0;
            m_per = 16'h0; m_high = 16'h0;
            ph = 8'h00; gh = 8'h00; phase = P_IDLE;
        end else begin
            cyc++;
            ph   = {ph[6:0], pwm};
            gnew = (ph[0] == ph[1] && ph[1] == ph[2]) ? ph[0] : gh[0];
            gh   = {gh[6:0], gnew};
`ifdef PWM_CAPTURE_FILTER_EN
            vh = gh;
`else
            vh = ph;
`endif
            acc_rise = vh[3] & ~vh[4];
            acc_fall = ~vh[3] & vh[4];
            en_q = m_en; hold_q = m_hold; os_q = m_os;
            if (bus.b_write_i && bus.b_addr_i == 8'h00)
                {m_en, m_hold, m_ie, m_os} = {bus.b_data_i[7:5], bus.b_data_i[0]};
            if (bus.b_write_i && bus.b_addr_i == 8'h01) begin
                if (bus.b_data_i[0]) m_valid = 1'b0;
                if (bus.b_data_i[1]) m_ovf = 1'b0;
            end
            if (!en_q) phase = P_IDLE;
            else if (phase == P_IDLE) phase = P_ARM;
            else if (phase == P_ARM) begin
                if (acc_rise) begin phase = P_HIGH; t_rise = cyc; end
            end else if (cyc - t_rise == MAXC) begin
                m_ovf = 1'b1;
                if (!hold_q) begin
                    m_per  = 16'(MAXC);
                    m_high = (phase == P_HIGH) ? 16'(MAXC) : 16'(t_fall - t_rise);
                end
                phase = P_ARM;
            end else if (phase == P_LOW && acc_rise) begin
                if (!hold_q) begin
                    m_per  = 16'(cyc - t_rise);
                    m_high = 16'(t_fall - t_rise);
                end
                m_valid = 1'b1;
                t_rise  = cyc;
                if (os_q) begin phase = P_IDLE; m_en = 1'b0; end
                else phase = P_HIGH;
            end else if (phase == P_HIGH && acc_fall) begin
                t_fall = cyc;
                phase  = P_LOW;
            end
            m_lvl = vh[1];
        end
    end

    function automatic logic [7:0] mread(input logic [7:0] a);
        case (a)
            8'h00:   return {m_en, m_hold, m_ie, 4'b0000, m_os};
            8'h01:   return {5'b00000, m_lvl, m_ovf, m_valid};
            8'h02:   return m_per[15:8];
            8'h03:   return m_per[7:0];
            8'h04:   return m_high[15:8];
            8'h05:   return m_high[7:0];
            default: return 8'h00;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if (bus.b_data_o !== mread(bus.b_addr_i)) begin
                errors++;
                if (nprint < 20) $display("FAIL model_read cyc %0d addr %h got %h want %h",
                                          cyc, bus.b_addr_i, bus.b_data_o, mread(bus.b_addr_i));
                nprint++;
            end
            checks++;
            if (irq !== (m_valid & m_ie)) begin
                errors++;
                if (nprint < 20) $display("FAIL model_irq cyc %0d got %b want %b", cyc, irq, m_valid & m_ie);
                nprint++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        tick(1);
        req_addr = a; busy = 1'b1;
        @(negedge clk);
        d = bus.b_data_o;
        #1 busy = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd(a, d);
        chk(name, d, exp);
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        tick(1);
        req_addr = a; wdata = d; busy = 1'b1; wr = 1'b1;
        tick(1);
        wr = 1'b0; busy = 1'b0;
    endtask

    task automatic set_wave(input int per, input int hi);
        pw_per = per; pw_high = hi; pw_mode = 1'b1; pw_seq++;
    endtask

    task automatic set_lvl(input logic v);
        pw_mode = 1'b0; pw_lvl = v;
    endtask

    initial begin
        logic [7:0] d;
        tick(3);
        chk_on = 1'b1;
        rd_chk("rst_ctl", 8'h00, 8'h00);
        rd_chk("rst_per_lo", 8'h03, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        nrst = 1'b1;
        tick(2);
        wr_reg(8'h07, 8'hFF);
        rd_chk("unmapped", 8'h07, 8'h00);

        // basic 100/30 measurement with interrupt enabled
        wr_reg(8'h00, 8'hA0);
        set_wave(100, 30);
        tick(350);
        rd_chk("a_ctl", 8'h00, 8'hA0);
        rd_chk("a_per_hi", 8'h02, 8'h00);
        rd_chk("a_per_lo", 8'h03, 8'h64);
        rd_chk("a_high_hi", 8'h04, 8'h00);
        rd_chk("a_high_lo", 8'h05, 8'h1E);
        rd(8'h01, d);
        chk("a_valid", d & 8'h03, 8'h01);
        chk("a_irq", {7'b0, irq}, 8'h01);

        // HOLD keeps old results while VALID still re-sets
        wr_reg(8'h00, 8'hE0);
        set_wave(200, 50);
        wr_reg(8'h01, 8'h01);
        tick(500);
        rd_chk("h_per_lo", 8'h03, 8'h64);
        rd_chk("h_high_lo", 8'h05, 8'h1E);
        rd(8'h01, d);
        chk("h_valid", d & 8'h03, 8'h01);
        wr_reg(8'h00, 8'hA0);
        tick(450);
        rd_chk("h2_per_lo", 8'h03, 8'hC8);
        rd_chk("h2_high_lo", 8'h05, 8'h32);

        // ONESHOT: one capture then EN self-clears
        wr_reg(8'h00, 8'h00);
        wr_reg(8'h01, 8'h03);
        set_wave(100, 30);
        wr_reg(8'h00, 8'h81);
        tick(300);
        rd_chk("o_ctl", 8'h00, 8'h01);
        rd_chk("o_per_lo", 8'h03, 8'h64);
        rd_chk("o_high_lo", 8'h05, 8'h1E);
        set_wave(150, 40);
        tick(400);
        rd_chk("o_per_kept", 8'h03, 8'h64);
        rd_chk("o_ctl_kept", 8'h00, 8'h01);

        // saturation at 100% duty
        wr_reg(8'h00, 8'h00);
        wr_reg(8'h01, 8'h03);
        set_lvl(1'b0);
        tick(10);
        wr_reg(8'h00, 8'h80);
        tick(5);
        set_lvl(1'b1);
        tick(70000);
        rd_chk("s_status", 8'h01, 8'h06);
        rd_chk("s_per_hi", 8'h02, 8'hFF);
        rd_chk("s_per_lo", 8'h03, 8'hFF);
        rd_chk("s_high_hi", 8'h04, 8'hFF);
        rd_chk("s_high_lo", 8'h05, 8'hFF);
        wr_reg(8'h01, 8'h03);
        set_lvl(1'b0); tick(50);
        set_lvl(1'b1); tick(40);
        set_lvl(1'b0); tick(60);
        set_lvl(1'b1); tick(20);
        rd_chk("s_rearm_per", 8'h03, 8'h64);
        rd_chk("s_rearm_high", 8'h05, 8'h28);
        rd_chk("s_rearm_sts", 8'h01, 8'h05);

        // reset pulse while in LOW
        wr_reg(8'h00, 8'hA0);
        set_wave(100, 30);
        tick(250);
        for (int i = 0; i < 200 && pw_ph != 70; i++) tick(1);
        nrst = 1'b0;
        set_lvl(1'b0);
        tick(3);
        nrst = 1'b1;
        tick(2);
        for (int a = 0; a < 6; a++) rd_chk("r_regs", 8'(a), 8'h00);
        chk("r_irq", {7'b0, irq}, 8'h00);
        wr_reg(8'h00, 8'h80);
        tick(10);
        set_lvl(1'b1);
        tick(30);
        rd_chk("r_no_valid", 8'h01, 8'h04);

        // two-cycle glitch on a low input
        wr_reg(8'h00, 8'h00);
        wr_reg(8'h01, 8'h03);
        set_lvl(1'b0);
        tick(10);
        wr_reg(8'h00, 8'h80);
        tick(10);
        set_lvl(1'b1); tick(2);
        set_lvl(1'b0); tick(48);
        set_lvl(1'b1); tick(30);
`ifdef PWM_CAPTURE_FILTER_EN
        rd_chk("g_status", 8'h01, 8'h04);
`else
        rd_chk("g_status", 8'h01, 8'h05);
        rd_chk("g_per_lo", 8'h03, 8'h32);
        rd_chk("g_high_lo", 8'h05, 8'h02);
`endif
        tick(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter CNT_BITS, default 16, giving the measurement counter width; legal range is 9..16.
REQ-002 SHALL have port clk_i  input  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port nrst_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port b_addr_i  input  8  register address.
REQ-005 SHALL have port b_data_i  input  8  write data.
REQ-006 SHALL have port b_data_o  output  8  read data, combinational from b_addr_i.
REQ-007 SHALL have port b_write_i  input  1  write strobe, sampled at clk_i.
REQ-008 SHALL have port pwm_i  input  1  asynchronous PWM input to be measured.
REQ-009 SHALL have port irq_o  output  1  level, high while STATUS.VALID=1 and CTL.IE=1.

Function
REQ-010 SHALL implement this register map:
- 0x00 CTL: [7]EN, [6]HOLD, [5]IE, [0]ONESHOT, read/write, other bits read 0.
- 0x01 STATUS: [0]VALID, [1]OVF, [2]synchronized pwm level; writing 1 to bit 0 or bit 1 clears that bit.
- 0x02/0x03 PERIOD high/low byte.
- 0x04/0x05 HIGH high/low byte.
- Unmapped addresses read 0x00 and ignore writes.
REQ-011 SHALL pass pwm_i through a 2-flop synchronizer, then a registered edge detector, giving 3 cycles from pin edge to accepted edge.
REQ-012 SHALL implement FSM states IDLE, ARM, HIGH, LOW.
REQ-013 FSM transitions: IDLE->ARM when EN=1; ARM->HIGH on an accepted rising edge; HIGH->LOW on a falling edge; LOW->HIGH on a rising edge; any state->IDLE when EN=0, taking effect the cycle after the write.
REQ-014 SHALL load period_cnt and high_cnt with 1 on the cycle a rising edge enters HIGH, and increment both by 1 each cycle thereafter.
REQ-015 SHALL freeze high_cnt while the FSM is in LOW.
REQ-016 On a rising edge in LOW, SHALL capture PERIOD=period_cnt and HIGH=high_cnt, restart both counters at 1, and set VALID.
- If HOLD=1, the PERIOD/HIGH registers are not updated, but VALID is still set.
REQ-017 ONESHOT=1: after the first capture, the FSM goes to IDLE and clears EN.
REQ-018 Counter saturation: when period_cnt reaches 2^CNT_BITS-1, the block SHALL:
- set OVF;
- load PERIOD=all-ones;
- load HIGH=high_cnt, or all-ones if still in HIGH;
- return to ARM.
This covers 0% and 100% duty inputs.
REQ-019 Result widths SHALL be zero-extended to 16 bits on read.
REQ-020 A write-1-to-clear on the same cycle as a hardware set SHALL leave the bit set.
REQ-021 A write to CTL setting EN while already in HIGH or LOW SHALL NOT restart the measurement.

Reset
REQ-022 On nrst_i low, the block SHALL set:
- CTL=0x00, STATUS bits 0 and 1 to 0;
- PERIOD=HIGH=0, counters=0;
- synchronizer flops=0, FSM=IDLE;
- irq_o=0, b_data_o=0x00 for address 0x00.
REQ-023 On deassertion mid-measurement, the block SHALL remain in IDLE with no spurious edge accepted.

Configuration
REQ-024 Macro PWM_CAPTURE_FILTER_EN:
- Defined: a glitch filter sits after the synchronizer and changes its output only after 3 consecutive identical samples, adding 2 cycles of latency.
- Undefined: the synchronizer output feeds the edge detector directly.

Verification
REQ-025 EN=1, pwm_i period 100 cycles with 30 high, after two rising edges -> PERIOD=0x0064, HIGH=0x001E, VALID=1, irq_o=1 if IE=1.
REQ-026 EN=1, pwm_i held high for 70000 cycles after a rising edge -> OVF=1, PERIOD=0xFFFF, HIGH=0xFFFF, FSM back in ARM.
REQ-027 HOLD=1 after first capture of 100/30, input changed to 200/50 -> PERIOD/HIGH stay 100/30, VALID re-sets after clear; HOLD=0 then next capture -> 200/50.
REQ-028 ONESHOT=1 with 100/30 input -> exactly one capture, then CTL.EN reads 0 and PERIOD is unchanged afterwards.
REQ-029 nrst_i pulsed low in LOW state -> all registers read reset values, no VALID on the next single edge.
REQ-030 With FILTER_EN defined, a 2-cycle high glitch on a low pwm_i -> no edge accepted; with FILTER_EN undefined, the same glitch -> FSM enters HIGH.
